// File: rtl/matmul_pkg.sv
// Shared types and constants for the 4x4 matrix-multiply sequencer.
package matmul_pkg;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  localparam logic [1:0] ERR_NONE       = 2'd0;
  localparam logic [1:0] ERR_EARLY_LAST = 2'd1;
  localparam logic [1:0] ERR_NO_LAST    = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT    = 2'd3;

  localparam int N             = 4;
  localparam int ELEM_W        = 8;
  localparam int RES_W         = 16;
  localparam int OPERAND_BEATS = 32;
  localparam int RESULT_BEATS  = 16;
  localparam int ELEMS         = N * N;

endpackage

// File: rtl/matmul_seq_timeout.sv
// Loadable down-counter; expired marks the enabled cycle that consumes the last count.
module matmul_seq_timeout #(
  parameter int TO_W = 11
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            load,
  input  logic [TO_W-1:0] load_value,
  input  logic            en,
  output logic            expired
);

  logic [TO_W-1:0] count_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else if (clr) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_value;
    end else if (en && (count_reg != '0)) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign expired = en && (count_reg == TO_W'(1));

endmodule

// File: rtl/matmul_seq_ctrl.sv
// Byte-stream to matmul_4x4 sequencer: load operands, start, wait with timeout, drain results.
// Optional perf counters are built when MATMUL_SEQ_CTRL_PERF_EN is defined.
module matmul_seq_ctrl
  import matmul_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TO_W           = 11
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [7:0]   in_data,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [15:0]  out_data,
  output logic         out_last,
  output logic         err,
  output logic [1:0]   err_code,
  output logic         mm_start,
  output logic [127:0] mm_a,
  output logic [127:0] mm_b,
  input  logic [255:0] mm_c,
  input  logic         mm_done
`ifdef MATMUL_SEQ_CTRL_PERF_EN
  ,
  output logic [31:0]  perf_cycles,
  output logic [15:0]  perf_jobs
`endif
);

  state_t state_reg, state_next;
  logic [4:0]        cnt_reg, cnt_next;
  logic [3:0]        idx_reg, idx_next;
  logic              err_reg, err_next;
  logic [1:0]        err_code_reg, err_code_next;
  logic              first_wait_reg, first_wait_next;
  logic              in_fire, out_fire, capture;
  logic              to_clr, to_load, to_en, to_expired;
  logic [ELEM_W-1:0] opnd_reg [OPERAND_BEATS];
  logic [RES_W-1:0]  res_reg  [RESULT_BEATS];

  assign in_ready  = (state_reg == ST_LOAD);
  assign mm_start  = (state_reg == ST_START);
  assign out_valid = (state_reg == ST_DRAIN);
  assign out_data  = out_valid ? res_reg[idx_reg] : '0;
  assign out_last  = out_valid && (idx_reg == 4'(RESULT_BEATS - 1));
  assign err       = err_reg;
  assign err_code  = err_code_reg;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  matmul_seq_timeout #(.TO_W(TO_W)) u_timeout (
    .clk        (clk),
    .rst        (rst),
    .clr        (to_clr),
    .load       (to_load),
    .load_value (TO_W'(TIMEOUT_CYCLES)),
    .en         (to_en),
    .expired    (to_expired)
  );

  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    idx_next        = idx_reg;
    err_next        = 1'b0;
    err_code_next   = err_code_reg;
    first_wait_next = first_wait_reg;
    capture         = 1'b0;
    to_clr          = 1'b0;
    to_load         = 1'b0;
    to_en           = 1'b0;
    case (state_reg)
      ST_LOAD: begin
        to_clr = 1'b1;
        if (in_fire) begin
          if (cnt_reg == 5'(OPERAND_BEATS - 1)) begin
            cnt_next = '0;
            if (in_last) begin
              state_next = ST_START;
            end else begin
              err_next      = 1'b1;
              err_code_next = ERR_NO_LAST;
            end
          end else if (in_last) begin
            cnt_next      = '0;
            err_next      = 1'b1;
            err_code_next = ERR_EARLY_LAST;
          end else begin
            cnt_next = cnt_reg + 5'd1;
          end
        end
      end
      ST_START: begin
        to_load         = 1'b1;
        first_wait_next = 1'b1;
        state_next      = ST_WAIT;
      end
      ST_WAIT: begin
        to_en           = 1'b1;
        first_wait_next = 1'b0;
        // A done still asserted from the previous job is only trusted after one WAIT cycle.
        if (mm_done && !first_wait_reg) begin
          capture    = 1'b1;
          idx_next   = '0;
          state_next = ST_DRAIN;
        end else if (to_expired) begin
          err_next      = 1'b1;
          err_code_next = ERR_TIMEOUT;
          state_next    = ST_LOAD;
        end
      end
      ST_DRAIN: begin
        if (out_fire) begin
          if (idx_reg == 4'(RESULT_BEATS - 1)) begin
            idx_next   = '0;
            state_next = ST_LOAD;
          end else begin
            idx_next = idx_reg + 4'd1;
          end
        end
      end
      default: state_next = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= ST_LOAD;
      cnt_reg        <= '0;
      idx_reg        <= '0;
      err_reg        <= 1'b0;
      err_code_reg   <= ERR_NONE;
      first_wait_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      idx_reg        <= idx_next;
      err_reg        <= err_next;
      err_code_reg   <= err_code_next;
      first_wait_reg <= first_wait_next;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < OPERAND_BEATS; gi++) begin : g_opnd
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          opnd_reg[gi] <= '0;
        end else if (in_fire && (cnt_reg == 5'(gi))) begin
          opnd_reg[gi] <= in_data;
        end
      end
    end

    // Operand beat b lands at byte b of the bus, which is exactly the row-major packing.
    for (gi = 0; gi < ELEMS; gi++) begin : g_bus
      assign mm_a[ELEM_W*gi +: ELEM_W] = opnd_reg[gi];
      assign mm_b[ELEM_W*gi +: ELEM_W] = opnd_reg[ELEMS + gi];
    end

    for (gi = 0; gi < RESULT_BEATS; gi++) begin : g_res
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          res_reg[gi] <= '0;
        end else if (capture) begin
          res_reg[gi] <= mm_c[RES_W*gi +: RES_W];
        end
      end
    end
  endgenerate

`ifdef MATMUL_SEQ_CTRL_PERF_EN
  logic [31:0] run_reg;
  logic [31:0] perf_cycles_reg;
  logic [15:0] perf_jobs_reg;

  // run_reg counts the START cycle plus every WAIT cycle seen so far.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_reg         <= '0;
      perf_cycles_reg <= '0;
      perf_jobs_reg   <= '0;
    end else begin
      if (state_reg == ST_START) begin
        run_reg <= 32'd1;
      end else if (state_reg == ST_WAIT) begin
        run_reg <= run_reg + 32'd1;
      end
      if (capture) begin
        perf_cycles_reg <= run_reg + 32'd1;
        perf_jobs_reg   <= perf_jobs_reg + 16'd1;
      end
    end
  end

  assign perf_cycles = perf_cycles_reg;
  assign perf_jobs   = perf_jobs_reg;
`endif

endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// Directed bench for matmul_seq_ctrl; a small matmul model stands in for the datapath.
module tb_matmul_seq_ctrl;

  localparam int TO = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [7:0]   in_data = '0;
  logic         in_last = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [15:0]  out_data;
  logic         out_last;
  logic         err;
  logic [1:0]   err_code;
  logic         mm_start;
  logic [127:0] mm_a, mm_b;
  logic [255:0] mm_c = '0;
  logic         mm_done = 1'b0;

  int checks = 0;
  int failures = 0;
  int err_pulses = 0;

  logic [7:0]  a_m [16];
  logic [7:0]  b_m [16];
  logic [15:0] exp_c [16];

  always #5 clk = ~clk;

  matmul_seq_ctrl #(.TIMEOUT_CYCLES(TO), .TO_W(5)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .err(err), .err_code(err_code),
    .mm_start(mm_start), .mm_a(mm_a), .mm_b(mm_b), .mm_c(mm_c), .mm_done(mm_done)
  );

  always @(posedge clk) if (err === 1'b1) err_pulses <= err_pulses + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] pack_op(input bit sel_b);
    logic [127:0] p;
    for (int b = 0; b < 16; b++) p[8*b +: 8] = sel_b ? b_m[b] : a_m[b];
    return p;
  endfunction

  function automatic logic [255:0] dp_model();
    logic [255:0] c;
    int s;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        s = 0;
        for (int k = 0; k < 4; k++) s += int'(a_m[4*i+k]) * int'(b_m[4*k+j]);
        c[16*(4*i+j) +: 16] = s[15:0];
      end
    return c;
  endfunction

  task automatic set_identity();
    for (int b = 0; b < 16; b++) begin
      a_m[b]   = (b % 5 == 0) ? 8'd1 : 8'd0;
      b_m[b]   = (b % 5 == 0) ? 8'd2 : 8'd0;
      exp_c[b] = (b % 5 == 0) ? 16'd2 : 16'd0;
    end
  endtask

  task automatic set_ramp();
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 4; k++) a_m[4*i+k] = 8'(i + k + 1);
    for (int b = 0; b < 16; b++) b_m[b] = 8'(b + 1);
    exp_c = '{16'd90,  16'd100, 16'd110, 16'd120,
              16'd118, 16'd132, 16'd146, 16'd160,
              16'd146, 16'd164, 16'd182, 16'd200,
              16'd174, 16'd196, 16'd218, 16'd240};
  endtask

  // Ends on the negedge after the final beat is accepted.
  task automatic send_job(input int n_beats, input int last_at);
    for (int b = 0; b < n_beats; b++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = (b < 16) ? a_m[b] : b_m[b-16];
      in_last  = (b == last_at);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Called in the START cycle; returns in the second WAIT cycle, capture follows on the next edge.
  task automatic run_datapath(input bit stale);
    chk("mm_start_pulse", 32'(mm_start), 32'd1);
    chk("mm_a_bus", 32'(mm_a === pack_op(1'b0)), 32'd1);
    chk("mm_b_bus", 32'(mm_b === pack_op(1'b1)), 32'd1);
    @(negedge clk);
    chk("mm_start_once", 32'(mm_start), 32'd0);
    chk("in_ready_wait", 32'(in_ready), 32'd0);
    in_valid = 1'b1;
    if (!stale) mm_c = dp_model();
    mm_done = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk(stale ? "stale_done_ignored" : "first_wait_ignored", 32'(out_valid), 32'd0);
    mm_c = dp_model();
  endtask

  task automatic drain(input bit toggle, input int stop_after);
    int got = 0;
    int cyc = 0;
    bit ph = 1'b1;
    while (got < stop_after && cyc < 100) begin
      @(negedge clk);
      cyc++;
      out_ready = toggle ? ph : 1'b1;
      ph = ~ph;
      if (out_valid) begin
        chk($sformatf("out_data[%0d]", got), 32'(out_data), 32'(exp_c[got]));
        chk($sformatf("out_last[%0d]", got), 32'(out_last), 32'(got == 15));
        if (out_ready) got++;
      end
    end
    chk("drain_beats", 32'(got), 32'(stop_after));
  endtask

  task automatic after_drain();
    @(negedge clk);
    out_ready = 1'b0;
    chk("out_valid_drop", 32'(out_valid), 32'd0);
    chk("in_ready_back", 32'(in_ready), 32'd1);
  endtask

  initial begin
    int bad;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_err_code", 32'(err_code), 32'd0);
    chk("rst_mm_start", 32'(mm_start), 32'd0);
    chk("rst_mm_a", 32'(mm_a == 128'd0), 32'd1);
    rst = 1'b0;

    // Identity times 2*identity, free-flowing sink.
    set_identity();
    send_job(32, 31);
    run_datapath(1'b0);
    drain(1'b0, 16);
    after_drain();
    mm_done = 1'b0;
    chk("no_err_job1", 32'(err_pulses), 32'd0);

    // Ramp matrices with a sink that stalls every other cycle.
    set_ramp();
    send_job(32, 31);
    run_datapath(1'b0);
    drain(1'b1, 16);
    after_drain();
    mm_done = 1'b0;

    // in_last on beat 10.
    send_job(11, 10);
    chk("early_err", 32'(err), 32'd1);
    chk("early_code", 32'(err_code), 32'd1);
    chk("early_no_start", 32'(mm_start), 32'd0);
    chk("early_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    chk("early_err_one_cycle", 32'(err), 32'd0);
    chk("early_code_holds", 32'(err_code), 32'd1);

    // Beat 31 without in_last.
    send_job(32, 99);
    chk("nolast_err", 32'(err), 32'd1);
    chk("nolast_code", 32'(err_code), 32'd2);
    chk("nolast_no_start", 32'(mm_start), 32'd0);

    // Clean job after the discards.
    set_identity();
    send_job(32, 31);
    run_datapath(1'b0);
    drain(1'b0, 16);
    after_drain();
    mm_done = 1'b0;

    // Datapath never finishes.
    send_job(32, 31);
    chk("to_mm_start", 32'(mm_start), 32'd1);
    bad = 0;
    for (int n = 1; n <= TO; n++) begin
      @(negedge clk);
      if (err !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b0) bad++;
    end
    chk("to_quiet_window", 32'(bad), 32'd0);
    @(negedge clk);
    chk("to_err", 32'(err), 32'd1);
    chk("to_code", 32'(err_code), 32'd3);
    chk("to_in_ready", 32'(in_ready), 32'd1);
    chk("to_out_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("err_pulse_total", 32'(err_pulses), 32'd3);

    // Reset in DRAIN at idx 7.
    set_ramp();
    send_job(32, 31);
    run_datapath(1'b0);
    drain(1'b0, 7);
    @(negedge clk);
    out_ready = 1'b0;
    chk("pre_rst_idx7", 32'(out_data), 32'(exp_c[7]));
    rst = 1'b1;
    #1;
    chk("rst_mid_out_valid", 32'(out_valid), 32'd0);
    chk("rst_mid_in_ready", 32'(in_ready), 32'd1);
    chk("rst_mid_err_code", 32'(err_code), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Next job restarts at idx 0; done is left high for the stale-done case after it.
    set_identity();
    send_job(32, 31);
    run_datapath(1'b0);
    drain(1'b0, 16);
    after_drain();

    // Done still high (with stale C) into the first WAIT cycle.
    set_ramp();
    send_job(32, 31);
    run_datapath(1'b1);
    drain(1'b0, 16);
    after_drain();
    mm_done = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
